mul_unit: RTL and testbench

- Iterative shift-add multiplier that sits directly downstream of the instruction decoder.
- Consumes the decoder's 3-bit ALUControl multiply encodings (MUL, UMULL, SMULL) plus the two register-file operands.
- Produces a 64-bit product and N/Z flag candidates for the condition/flag stage.
- Replaces a combinational multiplier so the datapath can stall on Busy instead of closing timing on a full-width array.

---
 rtl/mul_pkg.sv | 28 ++
 rtl/mul_sign_adj.sv | 12 +
 rtl/mul_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiply definitions: decoder ALUControl encodings, FSM states and counter sizing.
package mul_pkg;

   localparam logic [2:0] ALU_MUL   = 3'b100;
   localparam logic [2:0] ALU_UMULL = 3'b101;
   localparam logic [2:0] ALU_SMULL = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must hold 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic logic op_valid(input logic [2:0] op);
      logic ok;
      case (op)
         ALU_MUL, ALU_UMULL, ALU_SMULL: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mul_sign_adj.sv
// Conditional two's-complement negate; yields |x| when neg_i is the sign bit.
module mul_sign_adj #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   assign res_o = neg_i ? ('0 - val_i) : val_i;

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL, one multiplier bit per cycle.
// Define MUL_EARLY_TERM_EN to finish once the remaining multiplier bits are all zero.
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic [1:0]       FlagsNZ
);
   import mul_pkg::*;

   localparam int CW = cnt_width(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [2:0]       op_q, op_d;
   logic             sign_q, sign_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    iter_q, iter_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [1:0]       nz_q, nz_d;

   logic             start_ok;
   logic             is_smull;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [PW-1:0]    acc_sum;
   logic [PW-1:0]    prod;
   logic [WIDTH-1:0] res_lo, res_hi;
   logic [1:0]       res_nz;
   logic             last_iter;

   assign start_ok = Start && op_valid(ALUControl);
   assign is_smull = (ALUControl == ALU_SMULL);

   mul_sign_adj #(.W(WIDTH)) u_abs_a (
      .val_i (SrcA),
      .neg_i (is_smull && SrcA[WIDTH-1]),
      .res_o (abs_a)
   );

   mul_sign_adj #(.W(WIDTH)) u_abs_b (
      .val_i (SrcB),
      .neg_i (is_smull && SrcB[WIDTH-1]),
      .res_o (abs_b)
   );

   // Product after the current iteration's partial add, then sign-restored.
   assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

   mul_sign_adj #(.W(PW)) u_neg_res (
      .val_i (acc_sum),
      .neg_i (sign_q),
      .res_o (prod)
   );

   assign res_lo = prod[WIDTH-1:0];
   assign res_hi = (op_q == ALU_MUL) ? '0 : prod[PW-1:WIDTH];
   assign res_nz = (op_q == ALU_MUL) ? {res_lo[WIDTH-1], (res_lo == '0)}
                                     : {res_hi[WIDTH-1], ({res_hi, res_lo} == '0)};

`ifdef MUL_EARLY_TERM_EN
   assign last_iter = (iter_q == CW'(WIDTH - 1)) || (mplr_q[WIDTH-1:1] == '0);
`else
   assign last_iter = (iter_q == CW'(WIDTH - 1));
`endif

   // Next-state and datapath update for the multiply sequencer.
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = done_q;
      op_d    = op_q;
      sign_d  = sign_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      iter_d  = iter_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      nz_d    = nz_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d = RUN;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               op_d    = ALUControl;
               sign_d  = is_smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
               mcand_d = {{WIDTH{1'b0}}, abs_a};
               mplr_d  = abs_b;
               acc_d   = '0;
               iter_d  = '0;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
            end
         end
         RUN: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            iter_d  = iter_q + CW'(1);
            if (last_iter) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               lo_d    = res_lo;
               hi_d    = res_hi;
               nz_d    = res_nz;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_q    <= 3'b000;
         sign_q  <= 1'b0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         nz_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         iter_q  <= iter_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         nz_q    <= nz_d;
      end
   end

   assign Busy     = busy_q;
   assign Done     = done_q;
   assign ResultLo = lo_q;
   assign ResultHi = hi_q;
   assign FlagsNZ  = nz_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vectors, random ops against an arithmetic model,
// back-to-back, ignored starts and reset abort. Honours MUL_EARLY_TERM_EN for latency.
module tb_mul_unit;
   import mul_pkg::*;

`ifdef MUL_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [2:0]  ALUControl;
   logic [31:0] SrcA, SrcB;
   logic        Busy, Done;
   logic [31:0] ResultLo, ResultHi;
   logic [1:0]  FlagsNZ;

   int checks = 0;
   int errors = 0;

   logic [31:0] last_lo = 32'h0;
   logic [31:0] last_hi = 32'h0;
   logic [1:0]  last_nz = 2'b00;

   mul_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (Start),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .Busy       (Busy),
      .Done       (Done),
      .ResultLo   (ResultLo),
      .ResultHi   (ResultHi),
      .FlagsNZ    (FlagsNZ)
   );

   always #5 clk = ~clk;

   // Reference: full-precision product by plain arithmetic, then flag rules.
   task automatic ref_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic [31:0] hi, output logic [1:0] nz);
      logic [63:0] p;
      if (op == ALU_MUL)        p = {32'h0, a * b};
      else if (op == ALU_UMULL) p = {32'h0, a} * {32'h0, b};
      else                      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      lo = p[31:0];
      hi = (op == ALU_MUL) ? 32'h0 : p[63:32];
      nz = (op == ALU_MUL) ? {lo[31], (lo == 32'h0)} : {hi[31], ({hi, lo} == 64'h0)};
   endtask

   // Iteration count: full width, or highest set bit of the multiplier magnitude.
   function automatic int exp_k(input logic [2:0] op, input logic [31:0] b);
      logic [31:0] m;
      int k;
      m = (op == ALU_SMULL && b[31]) ? (32'd0 - b) : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      return EARLY ? k : 32;
   endfunction

   // Called at a negedge: issue Start, then count cycles until Done (bounded).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, output int cyc, output int busy_cnt);
      Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
      @(posedge clk); #1;
      Start = 1'b0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
      cyc = -1; busy_cnt = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         Start = 1'b0;
         if (Busy) busy_cnt++;
         if (Done) begin
            cyc = c;
            break;
         end
         if (c == restart_at) begin
            Start = 1'b1; ALUControl = ALU_UMULL; SrcA = $urandom; SrcB = $urandom;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = 32'h0; SrcB = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      if ({Busy, Done, ResultLo, ResultHi, FlagsNZ} !== 67'h0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b lo=%h hi=%h nz=%b, want all 0",
                  Busy, Done, ResultLo, ResultHi, FlagsNZ);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({Busy, Done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_release: got busy=%b done=%b, want 0 0", Busy, Done);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [7] = '{ALU_MUL, ALU_UMULL, ALU_SMULL, ALU_SMULL, ALU_MUL, ALU_UMULL, ALU_UMULL};
      logic [31:0] t_a  [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
      logic [31:0] t_b  [7] = '{32'd6, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd2, 32'd3, 32'd0};
      logic [31:0] t_lo [7] = '{32'd42, 32'h1, 32'hFFFFFFF1, 32'h0, 32'h0, 32'd15, 32'h0};
      logic [31:0] t_hi [7] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h0, 32'h0, 32'h0};
      logic [1:0]  t_nz [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
      int          t_k  [7] = '{3, 32, 3, 32, 2, 2, 1};
      int cyc, bcnt, k;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         k = EARLY ? t_k[i] : 32;
         do_op(t_op[i], t_a[i], t_b[i], 0, cyc, bcnt);
         checks++;
         if (cyc !== k + 1 || bcnt !== k) begin
            errors++;
            $display("FAIL dir%0d_latency: got done_cycle=%0d busy_cycles=%0d, want %0d %0d", i, cyc, bcnt, k + 1, k);
         end
         checks++;
         if ({ResultHi, ResultLo, FlagsNZ} !== {t_hi[i], t_lo[i], t_nz[i]}) begin
            errors++;
            $display("FAIL dir%0d_result: got hi=%h lo=%h nz=%b, want hi=%h lo=%h nz=%b",
                     i, ResultHi, ResultLo, FlagsNZ, t_hi[i], t_lo[i], t_nz[i]);
         end
         @(negedge clk);
         checks++;
         if (Done !== 1'b0 || {ResultHi, ResultLo} !== {t_hi[i], t_lo[i]}) begin
            errors++;
            $display("FAIL dir%0d_pulse_hold: got done=%b hi=%h lo=%h, want done=0 hi=%h lo=%h",
                     i, Done, ResultHi, ResultLo, t_hi[i], t_lo[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  ops [3] = '{ALU_MUL, ALU_UMULL, ALU_SMULL};
      logic [31:0] spec [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      logic [31:0] a, b, elo, ehi;
      logic [1:0]  enz;
      logic [2:0]  op;
      int cyc, bcnt, k;
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 2)];
         case ($urandom_range(0, 3))
            0:       begin a = $urandom; b = $urandom; end
            1:       begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
            2:       begin a = spec[$urandom_range(0, 4)]; b = spec[$urandom_range(0, 4)]; end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         ref_mul(op, a, b, elo, ehi, enz);
         k = exp_k(op, b);
         @(negedge clk);
         do_op(op, a, b, 0, cyc, bcnt);
         checks++;
         if (cyc !== k + 1 || bcnt !== k) begin
            errors++;
            $display("FAIL rnd%0d_latency: op=%b b=%h got done_cycle=%0d busy_cycles=%0d, want %0d %0d",
                     n, op, b, cyc, bcnt, k + 1, k);
         end
         checks++;
         if ({ResultHi, ResultLo, FlagsNZ} !== {ehi, elo, enz}) begin
            errors++;
            $display("FAIL rnd%0d_result: op=%b a=%h b=%h got hi=%h lo=%h nz=%b, want hi=%h lo=%h nz=%b",
                     n, op, a, b, ResultHi, ResultLo, FlagsNZ, ehi, elo, enz);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt, k;
      @(negedge clk);
      do_op(ALU_MUL, 32'h80000000, 32'd2, 0, cyc, bcnt);
      checks++;
      if (cyc !== exp_k(ALU_MUL, 32'd2) + 1 || {ResultLo, FlagsNZ} !== {32'h0, 2'b01}) begin
         errors++;
         $display("FAIL b2b_first: got done_cycle=%0d lo=%h nz=%b, want %0d lo=0 nz=01",
                  cyc, ResultLo, FlagsNZ, exp_k(ALU_MUL, 32'd2) + 1);
      end
      k = exp_k(ALU_MUL, 32'd3);
      do_op(ALU_MUL, 32'd3, 32'd3, 0, cyc, bcnt);
      checks++;
      if (cyc !== k + 1 || bcnt !== k || {ResultHi, ResultLo, FlagsNZ} !== {32'h0, 32'd9, 2'b00}) begin
         errors++;
         $display("FAIL b2b_second: got done_cycle=%0d busy=%0d hi=%h lo=%h nz=%b, want %0d %0d hi=0 lo=9 nz=00",
                  cyc, bcnt, ResultHi, ResultLo, FlagsNZ, k + 1, k);
      end
      last_lo = 32'd9; last_hi = 32'h0; last_nz = 2'b00;
   endtask

   task automatic test_invalid_start();
      logic [2:0] bad [3] = '{3'b011, 3'b111, 3'b000};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         Start = 1'b1; ALUControl = bad[i]; SrcA = $urandom; SrcB = $urandom;
         @(posedge clk); #1;
         Start = 1'b0;
         @(negedge clk);
         checks++;
         if ({Busy, Done, ResultHi, ResultLo, FlagsNZ} !== {2'b00, last_hi, last_lo, last_nz}) begin
            errors++;
            $display("FAIL invalid_op_%b: got busy=%b done=%b hi=%h lo=%h nz=%b, want busy=0 done=0 hi=%h lo=%h nz=%b",
                     bad[i], Busy, Done, ResultHi, ResultLo, FlagsNZ, last_hi, last_lo, last_nz);
         end
      end
   endtask

   task automatic test_busy_start();
      logic [31:0] a, b, elo, ehi;
      logic [1:0]  enz;
      int cyc, bcnt;
      a = 32'h12345678; b = 32'h9ABCDEF1;
      ref_mul(ALU_UMULL, a, b, elo, ehi, enz);
      @(negedge clk);
      do_op(ALU_UMULL, a, b, 10, cyc, bcnt);
      checks++;
      if (cyc !== 33 || bcnt !== 32 || {ResultHi, ResultLo, FlagsNZ} !== {ehi, elo, enz}) begin
         errors++;
         $display("FAIL busy_start_ignored: got done_cycle=%0d busy=%0d hi=%h lo=%h nz=%b, want 33 32 hi=%h lo=%h nz=%b",
                  cyc, bcnt, ResultHi, ResultLo, FlagsNZ, ehi, elo, enz);
      end
   endtask

   task automatic test_reset_abort();
      bit seen;
      @(negedge clk);
      Start = 1'b1; ALUControl = ALU_SMULL; SrcA = 32'hDEADBEEF; SrcB = 32'h80000001;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_before: got busy=%b, want 1", Busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({Busy, Done, ResultLo, ResultHi, FlagsNZ} !== 67'h0) begin
         errors++;
         $display("FAIL abort_reset_outputs: got busy=%b done=%b lo=%h hi=%h nz=%b, want all 0",
                  Busy, Done, ResultLo, ResultHi, FlagsNZ);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (Busy || Done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got busy/done activity=%b, want 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_invalid_start();
      test_busy_start();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
